// File: rtl/matrix_pkg.sv
// matrix_pkg: shared sizes, types and scan states for the LED matrix
package matrix_pkg;
  localparam int NCOL = 16;
  localparam int NROW = 8;
  typedef logic [3:0] col_idx_t;
  typedef logic [NROW-1:0] row_pat_t;
  typedef enum logic {BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/matrix_bank.sv
// matrix_bank: two 16x8 frame banks, one write port, combinational front-bank read
module matrix_bank
  import matrix_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  logic     wr_bank,
  input  col_idx_t wr_col,
  input  row_pat_t wr_data,
  input  logic     rd_bank,
  input  col_idx_t rd_col,
  output row_pat_t rd_data
);
  logic [1:0][NCOL-1:0][NROW-1:0] mem_q;
  assign rd_data = mem_q[rd_bank][rd_col];
  // reset clears both banks and wins over a write in the same cycle
  always_ff @(posedge clk)
    if (rst) mem_q <= '0;
    else if (wr_en) mem_q[wr_bank][wr_col] <= wr_data;
endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: column scan sequencer with blanking, dwell and tear-free bank swap
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DWELL     = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  col_idx_t wr_col,
  input  row_pat_t wr_data,
  input  logic     swap_req,
  output logic     swap_ack,
  output col_idx_t col_sel,
  output logic     col_en,
  output row_pat_t row,
  output logic     frame_start
);
  localparam int CMAX = DWELL > BLANK_CYC ? DWELL : BLANK_CYC;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  col_idx_t col_q, col_d;
  row_pat_t row_q, row_d, rd_data;
  logic front_q, front_d, ack_q, ack_d, en_q, en_d, fs_q, fs_d;
  logic blank_done, show_done, swap_now;
  matrix_bank u_bank (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_bank(~front_q), .wr_col(wr_col), .wr_data(wr_data),
    .rd_bank(front_q), .rd_col(col_q), .rd_data(rd_data)
  );
  assign blank_done = state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1);
  assign show_done  = state_q == SHOW && cnt_q == CW'(DWELL - 1);
  assign swap_now   = show_done && col_q == col_idx_t'(NCOL - 1) && swap_req;
  // next state, counters, swap decision and registered output values
  always_comb begin
    state_d = blank_done ? SHOW : show_done ? BLANK : state_q;
    cnt_d   = blank_done || show_done ? '0 : cnt_q + CW'(1);
    col_d   = show_done ? col_q + col_idx_t'(1) : col_q;
    front_d = front_q ^ swap_now;
    ack_d   = swap_now;
    fs_d    = blank_done && col_q == '0;
    en_d    = state_d == SHOW;
    row_d   = blank_done ? rd_data : show_done ? '0 : row_q;
  end
  // state and output registers, all cleared by reset
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      col_q   <= '0;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      front_q <= front_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
      row_q   <= row_d;
    end
  assign swap_ack    = ack_q;
  assign col_sel     = col_q;
  assign col_en      = en_q;
  assign row         = row_q;
  assign frame_start = fs_q;
endmodule

// File: doc/matrix_scan_ctrl.md
# matrix_scan_ctrl

Scan-side controller for the 16-column x 8-row LED dot matrix. It holds a double-buffered 16x8 frame store that the display logic writes column by column. It sequences the column scan with a programmable dwell time and an anti-ghosting blank interval, and drives the column select and row pattern to the matrix. Frame swaps happen only at frame boundaries, so the displayed image never tears.

## Interface
Parameters:
- DWELL, 1000, clock cycles each column is lit (≥1)
- BLANK_CYC, 2, clock cycles of blanking before each column (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write one column of the back bank this cycle
- wr_col  in  4  column index written (0–15)
- wr_data  in  8  row pattern for wr_col, bit i = row i lit
- swap_req  in  1  level request to exchange front/back banks at next frame boundary
- swap_ack  out  1  one-cycle pulse: swap performed
- col_sel  out  4  column currently scanned
- col_en  out  1  column driver enable, high only while lit
- row  out  8  row pattern for col_sel, 0 while blanked
- frame_start  out  1  one-cycle pulse on first lit cycle of column 0

## Operation
- Two banks, A and B, each 16x8; `front` bit selects the displayed bank; the other bank is the back bank.
- Writes: wr_en writes wr_data into back[wr_col]. Same column written twice → last write wins. A write never alters the front bank. The exception is a write in the swap cycle: it lands in the bank that becomes front.
- Scan FSM, two states:
  - BLANK: col_en=0, row=0. Lasts BLANK_CYC cycles, then → SHOW.
  - SHOW: col_en=1, row=front_bank[col_sel]. Lasts DWELL cycles.
  - At the end of SHOW, col_sel increments modulo 16 (15→0 wrap), then → BLANK.
- Swap: evaluated on the last SHOW cycle of column 15.
  - If swap_req=1, `front` toggles at that edge and swap_ack=1 on the following cycle.
  - Otherwise there is no swap and no ack.
- swap_req is level-sensitive. The requester drops it after seeing swap_ack. If it is held high, a swap occurs every frame.
- The new back bank keeps the old front contents; no copy or clear is performed.
- Reset outputs:
  - col_sel=0, col_en=0, row=0, swap_ack=0, frame_start=0.
  - State BLANK, dwell counter=0, front=A.
  - Both banks cleared to 0.
- Reset mid-operation: effective on the next edge regardless of state. Pending swaps and writes in that cycle are discarded.

## Timing
- Cycle 0 is the first cycle with rst low.
- Column period P = BLANK_CYC+DWELL. Frame period F = 16·P.
- Column k of frame f is lit on cycles f·F + k·P + BLANK_CYC through f·F + (k+1)·P − 1.
- All outputs are registered. row/col_en/col_sel change only on state or column transitions, never mid-dwell.
- frame_start is high on cycle f·F + BLANK_CYC.
- swap_ack is high on cycle (f+1)·F, the first blank cycle of column 0, when the swap was taken at the end of frame f.
- Write-to-display latency: a write becomes visible from the first frame after the next swap.
- Counter width is $clog2(max(DWELL,BLANK_CYC)). There is no overflow; the counter reloads at each state change.

## Structure
- matrix_pkg:
  - NCOL=16, NROW=8
  - typedef col_idx_t (4 bits), row_pat_t (8 bits)
  - scan state enum {BLANK, SHOW}
- Sub-module matrix_bank: 2x16x8 register file. It has a write port addressed by (bank, col), a combinational read port for the front bank, and a synchronous clear on rst.
- matrix_scan_ctrl contains the FSM, the dwell counter, column counter, front bit and swap handshake.

## Test plan
All scenarios use DWELL=4 and BLANK_CYC=2, giving P=6 and F=96.
- Reset, then idle:
  - All outputs are 0 on cycles 0–1.
  - col_en=1 with col_sel=0 and row=0 on cycles 2–5; frame_start=1 on cycle 2.
  - col_sel=1 lit on cycles 8–11; col_sel wraps 15→0 at cycle 96.
- Write back[3]=8'hA5 at cycle 10, hold swap_req:
  - swap_ack=1 on cycle 96 only.
  - row=8'hA5 with col_sel=3 on cycles 116–119.
  - Frame 0 shows all zeros.
- Write back[3]=8'h11 then back[3]=8'h22 before the swap → row=8'h22 in column 3 after the swap.
- No swap_req → front bank stays unchanged for 3 frames and swap_ack never asserts; writes stay invisible.
- swap_req held high continuously → swap_ack on cycles 96, 192 and 288; the display alternates between banks each frame.
- rst asserted during column 7 SHOW (cycle 45):
  - Next cycle: col_sel=0, col_en=0, row=0.
  - After release, the banks read zero and the timing restarts at cycle 0.
